uart_tx_arbiter: RTL and testbench

Shares a single UART transmitter (`uart_tx`) between `N_REQ` byte producers, such as `send_alphabet`-style message generators, LED/status reporters and debug dumpers. It runs a round-robin arbitration over per-requester valid/ready byte streams and registers the winning byte onto the transmitter's valid/ready input. It sits between the producers and `uart_tx` in the ULX3S top level and sequences every byte that reaches `ftdi_txd`.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SEND,
        ARB_LOCK
    } arb_state_t;

    localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational rotating-priority search starting after 'last'
module uart_rr_pick #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             any,
    output logic [ID_W-1:0]  winner
);

    int              v_idx;
    logic [ID_W-1:0] w_idx;

    // Scan from the lowest-priority offset down so the nearest hit after 'last' overwrites the rest.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        v_idx  = 0;
        w_idx  = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            v_idx = (int'(last) + off) % N_REQ;
            w_idx = ID_W'(v_idx);
            if (req[w_idx]) begin
                any    = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter in front of uart_tx; optional message lock via UART_ARB_LOCK_EN
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                         clk_25mhz,
    input  logic                         reset_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_valid,
    output logic [UART_BYTE_W-1:0]       tx_data,
    input  logic                         tx_ready,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy
);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [ID_W-1:0]        r_last;
    logic [ID_W-1:0]        r_grant_id;
    logic                   r_tx_valid;
    logic [UART_BYTE_W-1:0] r_tx_data;

    logic                   w_any;
    logic [ID_W-1:0]        w_winner;
    logic [ID_W-1:0]        w_sel;
    logic [N_REQ-1:0]       w_ready;
    logic                   w_accept;
    logic [UART_BYTE_W-1:0] w_bytes [N_REQ];

`ifdef UART_ARB_LOCK_EN
    logic                   r_last_flag;
`else
    logic                   w_unused_last;
    assign w_unused_last = ^req_last;
`endif

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_valid),
        .last   (r_last),
        .any    (w_any),
        .winner (w_winner)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = '0;
        w_sel        = w_winner;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_ready[w_winner] = 1'b1;
                    w_state_next      = ARB_SEND;
                end
            end
            ARB_SEND: begin
                if (tx_ready) begin
`ifdef UART_ARB_LOCK_EN
                    w_state_next = r_last_flag ? ARB_IDLE : ARB_LOCK;
`else
                    w_state_next = ARB_IDLE;
`endif
                end
            end
`ifdef UART_ARB_LOCK_EN
            ARB_LOCK: begin
                // Only the owner of the open message may continue; no timeout by design.
                w_sel               = r_grant_id;
                w_ready[r_grant_id] = req_valid[r_grant_id];
                if (req_valid[r_grant_id]) begin
                    w_state_next = ARB_SEND;
                end
            end
`endif
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    assign w_accept = |(req_valid & w_ready);

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_grant_id  <= '0;
            r_last      <= ID_W'(N_REQ - 1);
`ifdef UART_ARB_LOCK_EN
            r_last_flag <= 1'b1;
`endif
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_bytes[w_sel];
            r_grant_id <= w_sel;
            if (r_state == ARB_IDLE) begin
                r_last <= w_sel;
            end
`ifdef UART_ARB_LOCK_EN
            r_last_flag <= req_last[w_sel];
`endif
        end else if (r_state == ARB_SEND && tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign req_ready = reset_n ? w_ready : '0;
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk_25mhz = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(4)) dut (
        .clk_25mhz (clk_25mhz),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*8 +: 8] = b;
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        @(negedge clk_25mhz);
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    logic [7:0] seen [$];
    int         exp_idx;
    int         bad_data, bad_ready, bad_busy;
    int         k, z;
    logic       k_inc, z_inc;

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'h44434241;
        req_last  = '0;
        tx_ready  = 1'b1;
        @(negedge clk_25mhz);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // single request on requester 2
        apply_reset();
        req_valid = 4'b0100;
        set_byte(2, 8'h41);
        tx_ready  = 1'b1;
        #1;
        check("single_ready_same_cycle", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("single_tx_valid", 32'(tx_valid), 32'h1);
        check("single_tx_data", 32'(tx_data), 32'h41);
        check("single_grant", 32'(grant_id), 32'h2);
        check("single_busy", 32'(busy), 32'h1);
        tick();
        check("single_done_valid", 32'(tx_valid), 32'h0);
        check("single_done_busy", 32'(busy), 32'h0);

        // fairness: all valid, tx_ready pulsed every 10th cycle
        apply_reset();
        req_data  = 32'h44434241;
        req_valid = 4'hF;
        exp_idx   = 0;
        for (int c = 0; c < 80; c++) begin
            tx_ready = (c % 10 == 9);
            #1;
            if (tx_valid && tx_ready) begin
                check("fair_data", 32'(tx_data), 32'h41 + 32'(exp_idx % 4));
                check("fair_grant", 32'(grant_id), 32'(exp_idx % 4));
                exp_idx++;
            end
            tick();
        end
        check("fair_count", 32'(exp_idx), 32'd8);

        // backpressure: tx_ready low 50 cycles after tx_valid rises
        apply_reset();
        set_byte(0, 8'h55);
        set_byte(1, 8'h66);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0110;
        bad_data = 0; bad_ready = 0; bad_busy = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (tx_data !== 8'h55 || tx_valid !== 1'b1) bad_data++;
            if (req_ready !== 4'b0000) bad_ready++;
            if (busy !== 1'b1) bad_busy++;
            tick();
        end
        check("bp_data_stable", 32'(bad_data), 32'd0);
        check("bp_ready_low", 32'(bad_ready), 32'd0);
        check("bp_busy_high", 32'(bad_busy), 32'd0);
        tx_ready = 1'b1;
        #1;
        check("bp_handshake_valid", 32'(tx_valid), 32'h1);
        tick();
        #1;
        check("bp_after_valid", 32'(tx_valid), 32'h0);
        check("bp_next_accept_ready", 32'(req_ready), 32'h2);
        tick();
        check("bp_next_data", 32'(tx_data), 32'h66);
        check("bp_next_grant", 32'(grant_id), 32'h1);

        // lock vs interleave: requester 1 sends "HI" while requester 0 sends 'Z'
        apply_reset();
        tx_ready  = 1'b1;
        set_byte(0, 8'h59);
        req_last  = 4'b0001;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        seen.delete();
        k = 0;
        z = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid[1] = (k < 2);
            set_byte(1, (k == 0) ? 8'h48 : 8'h49);
            req_last[1]  = (k == 1);
            req_valid[0] = (z < 1);
            set_byte(0, 8'h5A);
            req_last[0]  = 1'b1;
            #1;
            k_inc = req_ready[1] && req_valid[1];
            z_inc = req_ready[0] && req_valid[0];
            if (tx_valid && tx_ready) seen.push_back(tx_data);
            tick();
            if (k_inc) k++;
            if (z_inc) z++;
        end
        req_valid = '0;
        check("lock_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
`ifdef UART_ARB_LOCK_EN
            check("lock_byte0", 32'(seen[0]), 32'h48);
            check("lock_byte1", 32'(seen[1]), 32'h49);
            check("lock_byte2", 32'(seen[2]), 32'h5A);
`else
            check("ilv_byte0", 32'(seen[0]), 32'h48);
            check("ilv_byte1", 32'(seen[1]), 32'h5A);
            check("ilv_byte2", 32'(seen[2]), 32'h49);
`endif
        end

        // reset mid-send, then requester 0 beats requester 3
        apply_reset();
        set_byte(3, 8'h44);
        req_valid = 4'b1000;
        tx_ready  = 1'b0;
        tick();
        check("mid_pre_valid", 32'(tx_valid), 32'h1);
        check("mid_pre_grant", 32'(grant_id), 32'h3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_grant", 32'(grant_id), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk_25mhz);
        reset_n   = 1'b1;
        set_byte(0, 8'h61);
        req_valid = 4'b1001;
        #1;
        check("mid_tie_ready", 32'(req_ready), 32'h1);
        tick();
        check("mid_tie_grant", 32'(grant_id), 32'h0);
        check("mid_tie_data", 32'(tx_data), 32'h61);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
